// File: rtl/ws2812b_frame_sequencer.sv
// rtl/ws2812b_frame_sequencer.sv - snapshots mask/intensity and streams one GRB word per LED, then latches
module ws2812b_frame_sequencer #(
  parameter int          NUM_LEDS     = 12,
  parameter int          LATCH_CYCLES = 2400,
  parameter logic [2:0]  COLOR_EN     = 3'b111
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                start,
  input  logic [NUM_LEDS-1:0] led_mask,
  input  logic [7:0]          intensity,
  output logic                px_valid,
  output logic [23:0]         px_data,
  input  logic                px_ready,
  input  logic                ser_busy,
  output logic                busy,
  output logic                frame_done
);

  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CNT_W = $clog2(LATCH_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t              state, state_nxt;
  logic [NUM_LEDS-1:0] snap_mask;
  logic [7:0]          snap_int;
  logic                start_pend;
  logic [IDX_W-1:0]    led_idx;
  logic [CNT_W-1:0]    latch_cnt;
  logic                pending;
  logic                launch;
  logic                latch_done;
  logic [7:0]          chan;

  // Any divergence from the snapshot counts as a refresh request, so changes never get lost.
  assign pending = start_pend | start | (led_mask != snap_mask) | (intensity != snap_int);

  assign chan     = snap_mask[led_idx] ? snap_int : 8'h00;
  assign px_valid = (state == SEND);
  assign px_data  = (state == SEND) ? {COLOR_EN[2] ? chan : 8'h00,
                                       COLOR_EN[1] ? chan : 8'h00,
                                       COLOR_EN[0] ? chan : 8'h00} : 24'h000000;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    latch_done = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          state_nxt = SEND;
          launch    = 1'b1;
        end
      end
      SEND: begin
        if (px_ready && (led_idx == LAST_IDX)) state_nxt = LATCH;
      end
      LATCH: begin
        if (!ser_busy && (latch_cnt == LAST_CNT)) begin
          state_nxt  = IDLE;
          latch_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state      <= IDLE;
      frame_done <= 1'b0;
      snap_mask  <= '0;
      snap_int   <= 8'h00;
      start_pend <= 1'b0;
      led_idx    <= '0;
      latch_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= latch_done;

      if (launch) begin
        snap_mask  <= led_mask;
        snap_int   <= intensity;
        led_idx    <= '0;
        start_pend <= 1'b0;
      end else if (start && (state != IDLE)) begin
        start_pend <= 1'b1;
      end

      if ((state == SEND) && px_ready && (led_idx != LAST_IDX)) begin
        led_idx <= led_idx + IDX_W'(1);
      end

      if (state == SEND) begin
        latch_cnt <= '0;
      end else if (state == LATCH) begin
        // The latch period only counts quiet line time; any serializer activity restarts it.
        if (ser_busy || (latch_cnt == LAST_CNT)) latch_cnt <= '0;
        else                                     latch_cnt <= latch_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// tb/tb_ws2812b_frame_sequencer.sv - randomized and directed bench against a frame-level reference model
module tb_ws2812b_frame_sequencer;
  localparam int NL = 12;
  localparam int LC = 2400;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        start = 1'b0;
  logic        px_ready = 1'b1;
  logic        ser_busy = 1'b0;
  logic [11:0] led_mask = 12'h001;
  logic [7:0]  intensity = 8'h20;
  logic        pxv_a, pxv_b, busy_a, busy_b, done_a, done_b;
  logic [23:0] pxd_a, pxd_b;

  always #5 clk = ~clk;

  ws2812b_frame_sequencer #(.NUM_LEDS(NL), .LATCH_CYCLES(LC), .COLOR_EN(3'b111)) dut_a (
    .clk(clk), .res_n(res_n), .start(start), .led_mask(led_mask), .intensity(intensity),
    .px_valid(pxv_a), .px_data(pxd_a), .px_ready(px_ready), .ser_busy(ser_busy),
    .busy(busy_a), .frame_done(done_a));

  ws2812b_frame_sequencer #(.NUM_LEDS(NL), .LATCH_CYCLES(LC), .COLOR_EN(3'b010)) dut_b (
    .clk(clk), .res_n(res_n), .start(start), .led_mask(led_mask), .intensity(intensity),
    .px_valid(pxv_b), .px_data(pxd_b), .px_ready(px_ready), .ser_busy(ser_busy),
    .busy(busy_b), .frame_done(done_b));

  int cyc = 0, checks = 0, errors = 0;
  int ready_mode = 0, busy_mode = 0;
  bit reasserted = 0;

  // Reference model: a frame in flight, words handed over so far, and the current quiet run.
  bit          m_in_frame = 0, m_done = 0, m_pend = 0;
  int          m_sent = 0, m_quiet = 0;
  logic [11:0] m_snap_mask = '0;
  logic [7:0]  m_snap_int = '0;
  int          frames_started = 0, frames_done = 0, last_xfer_cyc = 0, done_cyc = 0;
  logic [23:0] xq_a[$], xq_b[$];

  function automatic logic [23:0] word_of(input logic [2:0] en, input logic [11:0] m,
                                          input int i, input logic [7:0] it);
    logic [7:0] c;
    c = m[i] ? it : 8'h00;
    return {en[2] ? c : 8'h00, en[1] ? c : 8'h00, en[0] ? c : 8'h00};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    logic        ev;
    logic [23:0] ea, eb;
    case (ready_mode)
      0:       px_ready = 1'b1;
      1:       px_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: px_ready = 1'($urandom_range(0, 1));
    endcase
    case (busy_mode)
      0: ser_busy = 1'b0;
      1: begin
        ser_busy = 1'b0;
        if (m_in_frame && m_sent == NL) begin
          if (cyc - last_xfer_cyc < 100) ser_busy = 1'b1;
          else if (!reasserted && m_quiet == 500) begin
            ser_busy   = 1'b1;
            reasserted = 1;
          end
        end
      end
      default: begin
        if (m_in_frame && m_sent == NL) ser_busy = (cyc - last_xfer_cyc < 40) && ($urandom_range(0, 1) == 1);
        else                            ser_busy = 1'($urandom_range(0, 1));
      end
    endcase

    if (pxv_a && px_ready) xq_a.push_back(pxd_a);
    if (pxv_b && px_ready) xq_b.push_back(pxd_b);

    if (!res_n) begin
      m_in_frame = 0; m_done = 0; m_pend = 0; m_sent = 0; m_quiet = 0;
      m_snap_mask = '0; m_snap_int = '0;
    end else begin
      m_done = 0;
      if (!m_in_frame) begin
        if (m_pend || start || led_mask != m_snap_mask || intensity != m_snap_int) begin
          m_snap_mask = led_mask; m_snap_int = intensity;
          m_in_frame = 1; m_sent = 0; m_quiet = 0; m_pend = 0;
          frames_started++;
          xq_a.delete(); xq_b.delete();
        end
      end else begin
        if (start) m_pend = 1;
        if (m_sent < NL) begin
          if (px_ready) begin
            m_sent++;
            if (m_sent == NL) last_xfer_cyc = cyc + 1;
          end
        end else begin
          m_quiet = ser_busy ? 0 : m_quiet + 1;
          if (m_quiet == LC) begin
            m_in_frame = 0; m_done = 1; done_cyc = cyc + 1; frames_done++;
          end
        end
      end
    end

    @(posedge clk); #1;
    cyc++;

    ev = m_in_frame && (m_sent < NL);
    ea = ev ? word_of(3'b111, m_snap_mask, m_sent, m_snap_int) : 24'h0;
    eb = ev ? word_of(3'b010, m_snap_mask, m_sent, m_snap_int) : 24'h0;
    check("px_valid_a", pxv_a, ev);
    check("px_data_a", pxd_a, ea);
    check("busy_a", busy_a, m_in_frame);
    check("frame_done_a", done_a, m_done);
    check("px_valid_b", pxv_b, ev);
    check("px_data_b", pxd_b, eb);
    check("busy_b", busy_b, m_in_frame);
    check("frame_done_b", done_b, m_done);
  endtask

  task automatic wait_done(input int limit);
    int target, k;
    target = frames_done + 1;
    k = 0;
    while (frames_done < target && k < limit) begin tick(); k++; end
    check("frame_timeout", frames_done >= target, 1);
  endtask

  task automatic run_until_sent(input int n, input int limit);
    int k;
    k = 0;
    while (!(m_in_frame && m_sent == n) && k < limit) begin tick(); k++; end
    check("reach_word", m_in_frame && m_sent == n, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    int base;
    repeat (3) tick();
    check("rst_px_valid", pxv_a, 0);
    check("rst_px_data", pxd_a, 0);

    // Post-reset auto-refresh
    res_n = 1'b1;
    tick();
    check("launch_latency", pxv_a, 1);
    wait_done(6000);
    check("f1_count", xq_a.size(), NL);
    check("f1_word0", xq_a[0], 24'h202020);
    check("f1_word1", xq_a[1], 24'h000000);
    check("latch_len", done_cyc - last_xfer_cyc, LC);
    repeat (30) tick();
    check("no_refire", frames_started, 1);

    // Backpressure
    ready_mode = 1;
    pulse_start();
    wait_done(6000);
    ready_mode = 0;
    check("bp_count", xq_a.size(), NL);
    check("bp_word0", xq_a[0], 24'h202020);

    // Mid-frame change
    base = frames_started;
    pulse_start();
    run_until_sent(5, 100);
    led_mask = 12'h002;
    wait_done(6000);
    check("mid_old_w0", xq_a[0], 24'h202020);
    check("mid_old_w1", xq_a[1], 24'h000000);
    wait_done(6000);
    check("mid_new_w0", xq_a[0], 24'h000000);
    check("mid_new_w1", xq_a[1], 24'h202020);
    repeat (30) tick();
    check("mid_frames", frames_started - base, 2);

    // Start handling
    base = frames_started;
    pulse_start();
    run_until_sent(NL, 100);
    repeat (3) begin pulse_start(); tick(); tick(); end
    wait_done(6000);
    wait_done(6000);
    check("start_repeat_w1", xq_a[1], 24'h202020);
    repeat (30) tick();
    check("start_frames", frames_started - base, 2);

    // Latch gating
    busy_mode = 1; reasserted = 0;
    pulse_start();
    wait_done(8000);
    busy_mode = 0;
    check("gate_len", done_cyc - last_xfer_cyc, 3001);

    // Reset mid-SEND
    pulse_start();
    run_until_sent(7, 100);
    res_n = 1'b0;
    tick();
    check("abort_valid", pxv_a, 0);
    check("abort_busy", busy_a, 0);
    res_n = 1'b1;
    wait_done(6000);
    check("fresh_count", xq_b.size(), NL);
    check("fresh_b_w0", xq_b[0], 24'h000000);
    check("fresh_b_w1", xq_b[1], 24'h002000);
    check("fresh_a_w1", xq_a[1], 24'h202020);

    // Randomized traffic
    ready_mode = 2; busy_mode = 2;
    for (int k = 0; k < 12000; k++) begin
      if ($urandom_range(0, 599) == 0) led_mask = 12'($urandom);
      if ($urandom_range(0, 799) == 0) intensity = 8'($urandom);
      start = ($urandom_range(0, 299) == 0);
      tick();
    end
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
